fpu_stim_gen: RTL and testbench
===============================

# fpu_stim_gen

Synthesizable stimulus generator driving the `fpu` operand inputs from a preloaded vector memory and emitting latency-aligned golden results (result word, div-by-zero, overflow, sNaN) for end-of-pipe comparison. Sits on the input side of `fpu`. It is the transmitter to the end checker's receiver: every expected value it emits lines up with the matching `fpu` output.

## Interface
- `DEPTH`, 256: vector memory entries; power of two, ≥2.
- `LATENCY`, 4: `fpu` cycles from operand bus to `out`; ≥1.
- `AW`, $clog2(DEPTH): memory address width (derived).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ld_we`  in  1  vector memory write strobe.
- `ld_addr`  in  AW  write address.
- `ld_data`  in  104  vector: [31:0] opa, [63:32] opb, [66:64] fpu_op, [68:67] rmode, [100:69] exp result, [101] exp div_by_zero, [102] exp overflow, [103] exp snan.
- `num_vec`  in  AW+1  vectors to issue; sampled on accepted `start`.
- `start`  in  1  run request, single-cycle.
- `hold`  in  1  issue stall (bubble insertion).
- `dut_out`  in  32, `dut_dbz`/`dut_ovf`/`dut_snan`  in  1: `fpu` outputs, used only with the macro.
- `opa`, `opb`  out  32  operands to `fpu`.
- `fpu_op`  out  3, `rmode`  out  2: operation/rounding to `fpu`.
- `issue_valid`  out  1  operand bus carries a live vector.
- `exp_out`  out  32, `exp_dbz`/`exp_ovf`/`exp_snan`  out  1: aligned golden values.
- `exp_valid`  out  1  golden outputs live this cycle.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err_cnt`  out  16  saturating mismatch count.

## Operation
- FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: `start`=1 latches `num_vec`, clears read pointer and `err_cnt`. Next state is RUN if `num_vec`>0, else DONE. `num_vec`>DEPTH is clamped to DEPTH.
- RUN: each cycle with `hold`=0, register memory entry [rd_ptr] onto the operand outputs, set `issue_valid`=1, increment rd_ptr and issued count. With `hold`=1: `issue_valid`=0, operands hold their last value, pointer frozen. After the last vector issues, go to DRAIN.
- DRAIN: count LATENCY cycles (`hold` ignored), then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Expected path: LATENCY-deep shift register of {valid, exp fields}, loaded with the issued entry's golden fields. It shifts every cycle in every state; bubbles enter with valid=0. `exp_*` outputs are the tail stage.
- `ld_we` is honoured only in IDLE; writes while `busy` are dropped. The memory has no reset; contents survive `rst_n`.
- `start` while `busy` is ignored.
- Reset (any time, including mid-run): state IDLE; all outputs 0; pipeline valids 0; `err_cnt` 0.

## Timing
- Vector k is on the operand bus in cycle t_k (`issue_valid`=1).
- Its golden values appear with `exp_valid`=1 exactly in cycle t_k+LATENCY.
- First issue is 1 cycle after an accepted `start`; N back-to-back vectors take N cycles.
- `done` asserts LATENCY+1 cycles after the last issue; total = 1+N+LATENCY+1 cycles with no hold.
- With `num_vec`=0, `done` asserts the cycle after `start`.

## Configuration
- `FPU_STIM_CHECK_EN` defined: in any cycle with `exp_valid`=1 where `{dut_out,dut_dbz,dut_ovf,dut_snan}` ≠ `{exp_out,exp_dbz,exp_ovf,exp_snan}`, `err_cnt` increments on the next edge. It saturates at 16'hFFFF and clears on accepted `start`.
- Undefined: `err_cnt` is tied to 0 and the `dut_*` inputs are unused; ports remain present.

## Test plan
- Load 3 vectors (opa=0x3F800000, opb=0x40000000, fpu_op=0 → exp 0x40400000); start with num_vec=3 → issue_valid high for cycles 1–3, exp_valid for cycles 5–7 with correct fields, done in cycle 8.
- Hold for 2 cycles after the 1st issue → exactly 2 bubbles in both issue_valid and exp_valid, order preserved, done in cycle 10.
- num_vec=0 → no issue_valid, done=1 the cycle after start; num_vec=DEPTH+5 → exactly DEPTH issues, pointer wraps to 0 without extra issue.
- rst_n low mid-RUN → all outputs 0 immediately; a restart reissues from entry 0 with memory intact; ld_we during RUN leaves memory unchanged.
- With FPU_STIM_CHECK_EN: feed dut_* = exp_* except the overflow bit flipped on vector 2 → err_cnt=1 at end; matching run → err_cnt=0.

Source files
------------

// File: rtl/fpu_stim_gen.sv
// Replays preloaded fpu vectors onto the operand bus and emits golden results aligned to fpu latency.
// Define FPU_STIM_CHECK_EN to compare dut_* against the golden tail and count mismatches in err_cnt.
module fpu_stim_gen #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [103:0]  ld_data,
  input  logic [AW:0]   num_vec,
  input  logic          start,
  input  logic          hold,
  input  logic [31:0]   dut_out,
  input  logic          dut_dbz,
  input  logic          dut_ovf,
  input  logic          dut_snan,
  output logic [31:0]   opa,
  output logic [31:0]   opb,
  output logic [2:0]    fpu_op,
  output logic [1:0]    rmode,
  output logic          issue_valid,
  output logic [31:0]   exp_out,
  output logic          exp_dbz,
  output logic          exp_ovf,
  output logic          exp_snan,
  output logic          exp_valid,
  output logic          busy,
  output logic          done,
  output logic [15:0]   err_cnt
);
  localparam int EW = 35;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  logic [103:0]  mem [DEPTH];
  state_e        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [CW-1:0] drn_q, drn_d;
  logic [31:0]   opa_q, opa_d, opb_q, opb_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    rm_q, rm_d;
  logic          iv_q, iv_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [LATENCY-1:0] pv_q;
  logic [EW-1:0] pd_q [LATENCY];

  logic [AW-1:0] rd_addr;
  logic [103:0]  rd_vec;
  logic [AW:0]   nv_clamp;
  logic          start_ok;
  logic          load;

  assign start_ok = (state_q == S_IDLE) && start;
  assign nv_clamp = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
  // Entry 0 is fetched while idle so the first vector lands on the bus one cycle after start.
  assign rd_addr  = (state_q == S_IDLE) ? '0 : rd_ptr_q;
  assign rd_vec   = mem[rd_addr];

  // Vector memory has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ld_we && (state_q == S_IDLE)) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rem_d    = rem_q;
    drn_d    = drn_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d = '0;
          rem_d    = nv_clamp;
          if (nv_clamp != '0) begin
            load    = 1'b1;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (rem_q == '0) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else if (!hold) begin
          load = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drn_q == CW'(LATENCY - 1)) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      rd_ptr_d = rd_addr + AW'(1);
      rem_d    = rem_d - (AW+1)'(1);
    end
    iv_d  = load;
    opa_d = load ? rd_vec[31:0]   : opa_q;
    opb_d = load ? rd_vec[63:32]  : opb_q;
    op_d  = load ? rd_vec[66:64]  : op_q;
    rm_d  = load ? rd_vec[68:67]  : rm_q;
    exp_d = load ? rd_vec[103:69] : exp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      drn_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      rm_q     <= '0;
      iv_q     <= 1'b0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
      drn_q    <= drn_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      rm_q     <= rm_d;
      iv_q     <= iv_d;
      exp_q    <= exp_d;
    end
  end

  // Golden shift register fed from the operand-stage copy: tail lines up with fpu out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < LATENCY; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= iv_q;
      pd_q[0] <= exp_q;
      for (int i = 1; i < LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign opa         = opa_q;
  assign opb         = opb_q;
  assign fpu_op      = op_q;
  assign rmode       = rm_q;
  assign issue_valid = iv_q;
  assign exp_valid   = pv_q[LATENCY-1];
  assign exp_out     = pd_q[LATENCY-1][31:0];
  assign exp_dbz     = pd_q[LATENCY-1][32];
  assign exp_ovf     = pd_q[LATENCY-1][33];
  assign exp_snan    = pd_q[LATENCY-1][34];
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

`ifdef FPU_STIM_CHECK_EN
  logic [15:0] err_cnt_q;
  logic        mism;

  assign mism = exp_valid &&
                ({dut_out, dut_dbz, dut_ovf, dut_snan} != {exp_out, exp_dbz, exp_ovf, exp_snan});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (start_ok) begin
      err_cnt_q <= '0;
    end else if (mism && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_dut;
  assign unused_dut = ^{dut_out, dut_dbz, dut_ovf, dut_snan, start_ok};
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_fpu_stim_gen.sv
// Scoreboard bench for fpu_stim_gen: queued expectations from a memory model, checked by a monitor.
`timescale 1ns/1ps
module tb_fpu_stim_gen;
  localparam int DEPTH = 16;
  localparam int LAT   = 4;
  localparam int AW    = 4;
`ifdef FPU_STIM_CHECK_EN
  localparam int FLIP_ERR = 1;
`else
  localparam int FLIP_ERR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [103:0]  ld_data = '0;
  logic [AW:0]   num_vec = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [31:0]   dut_out;
  logic          dut_dbz, dut_ovf, dut_snan;
  logic [31:0]   opa, opb, exp_out;
  logic [2:0]    fpu_op;
  logic [1:0]    rmode;
  logic          issue_valid, exp_dbz, exp_ovf, exp_snan, exp_valid, busy, done;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  fpu_stim_gen #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start), .hold(hold),
    .dut_out(dut_out), .dut_dbz(dut_dbz), .dut_ovf(dut_ovf), .dut_snan(dut_snan),
    .opa(opa), .opb(opb), .fpu_op(fpu_op), .rmode(rmode), .issue_valid(issue_valid),
    .exp_out(exp_out), .exp_dbz(exp_dbz), .exp_ovf(exp_ovf), .exp_snan(exp_snan),
    .exp_valid(exp_valid), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [103:0] mem_m [DEPTH];
  logic [103:0] iq[$];
  logic [103:0] gq[$];
  int tq[$];
  int cyc = 0, start_cyc = 0, last_issue = 0, run_n = 0, n_issued = 0;
  int done_seen = 0, done_rel = 0, exp_tot = 0, exp_base = 0, rel = 0, t = 0;
  logic [63:0]  imask = '0, emask = '0;
  logic [103:0] mv;
  logic         flip_en = 1'b0;

  // Echo the golden stream back as the fpu result, optionally corrupting vector 2's overflow bit.
  assign dut_out  = exp_out;
  assign dut_dbz  = exp_dbz;
  assign dut_snan = exp_snan;
  assign dut_ovf  = exp_ovf ^ (flip_en && ((exp_tot - exp_base) == 1));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (exp_valid) exp_tot <= exp_tot + 1;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [127:0] outs_all();
    return 128'({opa, opb, fpu_op, rmode, issue_valid, exp_out, exp_dbz, exp_ovf, exp_snan,
                 exp_valid, busy, done, err_cnt});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      rel = cyc - start_cyc;
      if (issue_valid) begin
        if (iq.size() == 0) begin
          chk("issue_extra", 128'(iq.size()), 128'(1));
        end else begin
          mv = iq.pop_front();
          chk("operands", 128'({rmode, fpu_op, opb, opa}), 128'(mv[68:0]));
        end
        if (rel >= 0 && rel < 64) imask[rel] = 1'b1;
        n_issued++;
        last_issue = cyc;
        tq.push_back(cyc);
      end
      if (exp_valid) begin
        if (gq.size() == 0) begin
          chk("exp_extra", 128'(gq.size()), 128'(1));
        end else begin
          mv = gq.pop_front();
          chk("golden", 128'({exp_snan, exp_ovf, exp_dbz, exp_out}), 128'(mv[103:69]));
        end
        if (tq.size() != 0) begin
          t = tq.pop_front();
          chk("exp_latency", 128'(cyc - t), 128'(LAT));
        end
        if (rel >= 0 && rel < 64) emask[rel] = 1'b1;
      end
      if (done) begin
        done_seen = 1;
        done_rel  = rel;
        chk("done_time", 128'(cyc), 128'((run_n == 0) ? start_cyc + 1 : last_issue + LAT + 1));
      end
    end
  end

  task automatic load(input int a, input logic [103:0] v);
    ld_we = 1'b1; ld_addr = a[AW-1:0]; ld_data = v;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  // hmode: 0 no hold, 1 hold two cycles after first issue, 2 random hold plus writes while busy.
  task automatic run(input int n, input int hmode, input int exp_done,
                     input logic [63:0] exp_im, input logic [63:0] exp_em);
    int ne;
    logic [127:0] r;
    ne = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < ne; i++) begin
      iq.push_back(mem_m[i]);
      gq.push_back(mem_m[i]);
    end
    run_n = ne; n_issued = 0; done_seen = 0; imask = '0; emask = '0;
    start = 1'b1; num_vec = n[AW:0]; start_cyc = cyc; exp_base = exp_tot;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 1000 && done_seen == 0; k++) begin
      case (hmode)
        1:       hold = ((cyc - start_cyc) == 1) || ((cyc - start_cyc) == 2);
        2:       hold = ($urandom_range(0, 3) == 0);
        default: hold = 1'b0;
      endcase
      ld_we = (hmode == 2) && busy;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      ld_addr = r[AW-1:0];
      ld_data = r[103:0];
      @(posedge clk); #1;
    end
    hold = 1'b0; ld_we = 1'b0;
    chk("done_seen", 128'(done_seen), 128'(1));
    chk("issued_cnt", 128'(n_issued), 128'(ne));
    chk("queues_empty", 128'(iq.size() + gq.size()), 128'(0));
    if (exp_done >= 0) begin
      chk("done_rel", 128'(done_rel), 128'(exp_done));
      chk("issue_mask", 128'(imask), 128'(exp_im));
      chk("exp_mask", 128'(emask), 128'(exp_em));
    end
  endtask

  initial begin
    logic [103:0] v;
    logic [127:0] r;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_all(), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      v = r[103:0];
      if (i < 3) begin
        v = '0;
        v[31:0]   = 32'h3F800000;
        v[63:32]  = 32'h40000000;
        v[100:69] = 32'h40400000;
      end
      mem_m[i] = v;
      load(i, v);
    end

    run(3, 0, 8, 64'hE, 64'hE0);
    run(3, 1, 10, 64'h32, 64'h320);
    run(0, 0, 1, 64'h0, 64'h0);
    run(DEPTH + 5, 0, DEPTH + LAT + 1, 64'h1FFFE, 64'h1FFFE0);
    repeat (6) run($urandom_range(1, DEPTH + 3), 2, -1, 64'h0, 64'h0);

    // Reset in the middle of a run, then restart from entry 0.
    for (int i = 0; i < 10; i++) begin
      iq.push_back(mem_m[i]);
      gq.push_back(mem_m[i]);
    end
    run_n = 10; n_issued = 0; start = 1'b1; num_vec = 5'd10; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_issued", 128'(n_issued), 128'(3));
    rst_n = 1'b0;
    #1;
    chk("reset_midrun", outs_all(), 128'(0));
    iq.delete(); gq.delete(); tq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(5, 0, 5 + LAT + 1, 64'h3E, 64'h3E0);
    run(DEPTH, 0, -1, 64'h0, 64'h0);

    flip_en = 1'b1;
    run(3, 0, -1, 64'h0, 64'h0);
    chk("err_cnt_flip", 128'(err_cnt), 128'(FLIP_ERR));
    flip_en = 1'b0;
    run(3, 0, -1, 64'h0, 64'h0);
    chk("err_cnt_match", 128'(err_cnt), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
